// File: rtl/aes_128_inv_control_4clk_if.sv
// ---------------------------------------------------------------------------
// aes_128_inv_control_4clk_if
//   Host-side handshake bundle of the AES-128 inverse-cipher sequencer.
//   Handshake: in_en is a one-cycle request pulse; it is accepted only when
//   busy is 0 in the same cycle. busy stays 1 from the cycle after acceptance
//   through the out_en cycle. out_en is a one-cycle completion pulse. An in_en
//   seen while busy is dropped and answered one cycle later by
//   in_en_collision_irq_pulse.
//   Signals:
//     in_en                      host -> seq  block request pulse
//     key_new                    host -> seq  key differs from cached expansion
//     busy                       seq  -> host sequencer not in IDLE
//     out_en                     seq  -> host plaintext valid pulse
//     in_en_collision_irq_pulse  seq  -> host request dropped while busy
// ---------------------------------------------------------------------------
interface aes_128_inv_control_4clk_if;
    logic in_en;
    logic key_new;
    logic busy;
    logic out_en;
    logic in_en_collision_irq_pulse;

    modport master (
        output in_en,
        output key_new,
        input  busy,
        input  out_en,
        input  in_en_collision_irq_pulse
    );

    modport slave (
        input  in_en,
        input  key_new,
        output busy,
        output out_en,
        output in_en_collision_irq_pulse
    );
endinterface

// File: rtl/aes_128_inv_control_4clk.sv
// ---------------------------------------------------------------------------
// aes_128_inv_control_4clk
//   Sequencer for the AES-128 inverse cipher datapath. On an accepted request
//   it optionally expands the cipher key forward into the round-key store,
//   performs the initial AddRoundKey with rk[10], then runs inverse rounds
//   using round keys 9 down to 0 (CLK_PER_ROUND clocks each) and pulses
//   out_en.
//   Ports:
//     clk               clock, rising edge
//     kill_n            asynchronous active-low reset
//     host              handshake bundle (in_en, key_new, busy, out_en, irq)
//     key_exp_en        forward key-expansion step enable
//     key_wr            write current expanded key at round_key_idx
//     round_key_idx     round-key store index 0..10
//     load_state        load state = ciphertext ^ rk[10]
//     round_en          inverse-round datapath enable
//     round_done        last phase of a round, state register updates
//     bypass_invmixcol  final round: skip InvMixColumns
//     dbg_state         current FSM state encoding
//   All outputs are decoded from registers only.
// ---------------------------------------------------------------------------
module aes_128_inv_control_4clk #(
    parameter int CLK_PER_ROUND = 4,   // 2..8
    parameter int KEY_EXP_CLK   = 1    // 1..4
) (
    input  logic                           clk,
    input  logic                           kill_n,
    aes_128_inv_control_4clk_if.slave      host,
    output logic                           key_exp_en,
    output logic                           key_wr,
    output logic [3:0]                     round_key_idx,
    output logic                           load_state,
    output logic                           round_en,
    output logic                           round_done,
    output logic                           bypass_invmixcol,
    output logic [2:0]                     dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY_EXP  = 3'd1,
        S_INIT_ADD = 3'd2,
        S_ROUNDS   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [1:0] KEY_LAST   = 2'(KEY_EXP_CLK - 1);
    localparam logic [2:0] PHASE_LAST = 3'(CLK_PER_ROUND - 1);

    state_t     state_q, state_d;
    logic [3:0] step_q,  step_d;    // key-expansion step 0..10
    logic [1:0] sub_q,   sub_d;     // clock within an expansion step
    logic [2:0] phase_q, phase_d;   // clock within an inverse round
    logic [3:0] rnd_q,   rnd_d;     // current round key index 9..0
    logic       kv_q,    kv_d;      // cached key expansion is valid
    logic       irq_q,   irq_d;

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state_q <= S_IDLE;
            step_q  <= 4'd0;
            sub_q   <= 2'd0;
            phase_q <= 3'd0;
            rnd_q   <= 4'd0;
            kv_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sub_q   <= sub_d;
            phase_q <= phase_d;
            rnd_q   <= rnd_d;
            kv_q    <= kv_d;
            irq_q   <= irq_d;
        end
    end

    // Next-state logic. A request arriving outside IDLE changes nothing but
    // the collision pulse.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        sub_d   = sub_q;
        phase_d = phase_q;
        rnd_d   = rnd_q;
        kv_d    = kv_q;
        irq_d   = host.in_en & (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (host.in_en) begin
                    step_d  = 4'd0;
                    sub_d   = 2'd0;
                    phase_d = 3'd0;
                    rnd_d   = 4'd9;
                    state_d = (host.key_new || !kv_q) ? S_KEY_EXP : S_INIT_ADD;
                end
            end
            S_KEY_EXP: begin
                // Step 0 only stores the cipher key and always lasts one cycle.
                if (step_q == 4'd0) begin
                    step_d = 4'd1;
                    sub_d  = 2'd0;
                end else if (sub_q == KEY_LAST) begin
                    if (step_q == 4'd10) begin
                        kv_d    = 1'b1;
                        state_d = S_INIT_ADD;
                    end else begin
                        step_d = step_q + 4'd1;
                        sub_d  = 2'd0;
                    end
                end else begin
                    sub_d = sub_q + 2'd1;
                end
            end
            S_INIT_ADD: begin
                rnd_d   = 4'd9;
                phase_d = 3'd0;
                state_d = S_ROUNDS;
            end
            S_ROUNDS: begin
                if (phase_q == PHASE_LAST) begin
                    if (rnd_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        rnd_d   = rnd_q - 4'd1;
                        phase_d = 3'd0;
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        host.busy                      = (state_q != S_IDLE);
        host.out_en                    = (state_q == S_DONE);
        host.in_en_collision_irq_pulse = irq_q;
        key_exp_en                     = 1'b0;
        key_wr                         = 1'b0;
        round_key_idx                  = 4'd0;
        load_state                     = 1'b0;
        round_en                       = 1'b0;
        round_done                     = 1'b0;
        bypass_invmixcol               = 1'b0;
        dbg_state                      = state_q;

        case (state_q)
            S_KEY_EXP: begin
                round_key_idx = step_q;
                key_exp_en    = (step_q != 4'd0);
                key_wr        = (step_q == 4'd0) || (sub_q == KEY_LAST);
            end
            S_INIT_ADD: begin
                round_key_idx = 4'd10;
                load_state    = 1'b1;
            end
            S_ROUNDS: begin
                round_key_idx    = rnd_q;
                round_en         = 1'b1;
                round_done       = (phase_q == PHASE_LAST);
                bypass_invmixcol = (rnd_q == 4'd0);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aes_128_inv_control_4clk.sv
// ---------------------------------------------------------------------------
// tb_aes_128_inv_control_4clk
//   Two sequencer instances: dut_a (4 clk/round, 1 clk/key step) and dut_b
//   (2 clk/round, 3 clk/key step). Every accepted request pushes the full
//   expected per-cycle output trace into that instance's expected queue;
//   every cycle pops one entry per instance and compares all outputs.
//   Output word: {busy, key_exp_en, key_wr, idx[3:0], load_state, round_en,
//                 round_done, bypass_invmixcol, out_en, irq}.
// ---------------------------------------------------------------------------
module tb_aes_128_inv_control_4clk;
    localparam int W = 13;

    logic clk = 1'b0;
    logic kill_n = 1'b1;
    always #5 clk = ~clk;

    aes_128_inv_control_4clk_if if_a ();
    aes_128_inv_control_4clk_if if_b ();

    logic       kee_a, kwr_a, ld_a, ren_a, rd_a, byp_a;
    logic [3:0] idx_a;
    logic [2:0] dbg_a;
    logic       kee_b, kwr_b, ld_b, ren_b, rd_b, byp_b;
    logic [3:0] idx_b;
    logic [2:0] dbg_b;

    aes_128_inv_control_4clk #(.CLK_PER_ROUND(4), .KEY_EXP_CLK(1)) dut_a (
        .clk(clk), .kill_n(kill_n), .host(if_a),
        .key_exp_en(kee_a), .key_wr(kwr_a), .round_key_idx(idx_a),
        .load_state(ld_a), .round_en(ren_a), .round_done(rd_a),
        .bypass_invmixcol(byp_a), .dbg_state(dbg_a)
    );

    aes_128_inv_control_4clk #(.CLK_PER_ROUND(2), .KEY_EXP_CLK(3)) dut_b (
        .clk(clk), .kill_n(kill_n), .host(if_b),
        .key_exp_en(kee_b), .key_wr(kwr_b), .round_key_idx(idx_b),
        .load_state(ld_b), .round_en(ren_b), .round_done(rd_b),
        .bypass_invmixcol(byp_b), .dbg_state(dbg_b)
    );

    wire [W-1:0] act_a = {if_a.busy, kee_a, kwr_a, idx_a, ld_a, ren_a, rd_a,
                          byp_a, if_a.out_en, if_a.in_en_collision_irq_pulse};
    wire [W-1:0] act_b = {if_b.busy, kee_b, kwr_b, idx_b, ld_b, ren_b, rd_b,
                          byp_b, if_b.out_en, if_b.in_en_collision_irq_pulse};

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit m_kv_a = 1'b0;
    bit m_kv_b = 1'b0;
    int a_out_cyc = -1;
    int b_out_cyc = -1;
    int a_out_n = 0;
    int b_out_n = 0;

    function automatic logic [W-1:0] mk(input logic kee, input logic kwr,
                                        input logic [3:0] idx, input logic ld,
                                        input logic ren, input logic rd,
                                        input logic byp, input logic oen);
        return {1'b1, kee, kwr, idx, ld, ren, rd, byp, oen, 1'b0};
    endfunction

    task automatic q_push(input bit sel, input logic [W-1:0] w);
        if (sel) exp_b.push_back(w);
        else     exp_a.push_back(w);
    endtask

    // Expected trace for the cycles following an accepted request.
    task automatic push_trace(input bit sel, input bit expand, input int cpr, input int kec);
        if (expand) begin
            q_push(sel, mk(0, 1, 4'd0, 0, 0, 0, 0, 0));
            for (int s = 1; s <= 10; s++)
                for (int j = 0; j < kec; j++)
                    q_push(sel, mk(1, j == kec - 1, 4'(s), 0, 0, 0, 0, 0));
        end
        q_push(sel, mk(0, 0, 4'd10, 1, 0, 0, 0, 0));
        for (int r = 9; r >= 0; r--)
            for (int p = 0; p < cpr; p++)
                q_push(sel, mk(0, 0, 4'(r), 0, 1, p == cpr - 1, r == 0, 0));
        q_push(sel, mk(0, 0, 4'd0, 0, 0, 0, 0, 1));
    endtask

    // Compare this cycle's outputs, update models, drive inputs, advance.
    task automatic step_cycle(input logic a_en, input logic a_kn,
                              input logic b_en, input logic b_kn);
        logic [W-1:0] ea, eb;
        ea = (exp_a.size() > 0) ? exp_a.pop_front() : '0;
        eb = (exp_b.size() > 0) ? exp_b.pop_front() : '0;
        n_vec++;
        if (act_a !== ea) begin
            n_err++;
            $display("FAIL dut_a_outputs cyc=%0d got=%h expected=%h", cyc, act_a, ea);
        end
        n_vec++;
        if (act_b !== eb) begin
            n_err++;
            $display("FAIL dut_b_outputs cyc=%0d got=%h expected=%h", cyc, act_b, eb);
        end
        if (if_a.out_en === 1'b1) begin a_out_n++; a_out_cyc = cyc; end
        if (if_b.out_en === 1'b1) begin b_out_n++; b_out_cyc = cyc; end
        if (a_en) begin
            if (!ea[W-1]) begin
                push_trace(1'b0, a_kn || !m_kv_a, 4, 1);
                m_kv_a = 1'b1;
            end else if (exp_a.size() > 0) exp_a[0] = exp_a[0] | W'(1);
            else exp_a.push_back(W'(1));
        end
        if (b_en) begin
            if (!eb[W-1]) begin
                push_trace(1'b1, b_kn || !m_kv_b, 2, 3);
                m_kv_b = 1'b1;
            end else if (exp_b.size() > 0) exp_b[0] = exp_b[0] | W'(1);
            else exp_b.push_back(W'(1));
        end
        if_a.in_en = a_en; if_a.key_new = a_kn;
        if_b.in_en = b_en; if_b.key_new = b_kn;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step_cycle(0, 0, 0, 0);
    endtask

    task automatic check_lat(input string name, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        if_a.in_en = 0; if_a.key_new = 0; if_b.in_en = 0; if_b.key_new = 0;
        #2 kill_n = 1'b0;
        @(posedge clk); #1;
        run_idle(3);
        kill_n = 1'b1;
        run_idle(2);
    endtask

    task automatic test_first_block_expands();
        int t0;
        t0 = cyc; a_out_cyc = -1;
        step_cycle(1, 0, 0, 0);
        run_idle(58);
        check_lat("first_block_latency", a_out_cyc - t0, 53);
    endtask

    task automatic test_cached_block();
        int t0;
        t0 = cyc; a_out_cyc = -1;
        step_cycle(1, 0, 0, 0);
        run_idle(46);
        check_lat("cached_latency", a_out_cyc - t0, 42);
    endtask

    task automatic test_key_new();
        int t0;
        t0 = cyc; a_out_cyc = -1;
        step_cycle(1, 1, 0, 0);
        run_idle(58);
        check_lat("key_new_latency", a_out_cyc - t0, 53);
    endtask

    task automatic test_collision_back_to_back();
        int t0, n0;
        t0 = cyc; a_out_cyc = -1; n0 = a_out_n;
        step_cycle(1, 0, 0, 0);
        run_idle(9);
        step_cycle(1, 1, 0, 0);     // cycle 10, dropped
        run_idle(31);
        step_cycle(1, 1, 0, 0);     // cycle 42 (DONE), dropped
        check_lat("collision_first_out", a_out_cyc - t0, 42);
        check_lat("collision_out_count", a_out_n - n0, 1);
        step_cycle(1, 0, 0, 0);     // cycle 43, accepted with cached key
        run_idle(48);
        check_lat("back_to_back_out", a_out_cyc - t0, 85);
        check_lat("back_to_back_count", a_out_n - n0, 2);
    endtask

    task automatic test_kill();
        int t0, n0;
        t0 = cyc; n0 = a_out_n;
        step_cycle(1, 0, 0, 0);
        run_idle(19);
        kill_n = 1'b0;
        #1;
        n_vec++;
        if (act_a !== '0) begin
            n_err++;
            $display("FAIL kill_outputs got=%h expected=%h", act_a, {W{1'b0}});
        end
        exp_a.delete(); exp_b.delete();
        m_kv_a = 1'b0; m_kv_b = 1'b0;
        run_idle(3);
        kill_n = 1'b1;
        run_idle(30);
        check_lat("kill_no_out_en", a_out_n - n0, 0);
        t0 = cyc; a_out_cyc = -1;
        step_cycle(1, 0, 0, 0);
        run_idle(56);
        check_lat("after_kill_expands", a_out_cyc - t0, 53);
    endtask

    task automatic test_params_b();
        int t0;
        t0 = cyc; b_out_cyc = -1;
        step_cycle(0, 0, 1, 0);
        run_idle(57);
        check_lat("b_expand_latency", b_out_cyc - t0, 53);
        t0 = cyc; b_out_cyc = -1;
        step_cycle(0, 0, 1, 0);
        run_idle(26);
        check_lat("b_cached_latency", b_out_cyc - t0, 22);
    endtask

    initial begin
        test_reset();
        test_first_block_expands();
        test_cached_block();
        test_key_new();
        test_collision_back_to_back();
        test_kill();
        test_params_b();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
